violation_reset_ctrl: RTL and testbench
=======================================

VIOLATION_RESET_CTRL -- requirements
Module: violation_reset_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, is the number of cycles the reset output stays high per accepted violation; legal range 2..255.
REQ-002 Parameter COOLDOWN_CYCLES, default 2, is the number of reset-low cycles enforced after each reset pulse; legal range 1..15.
REQ-003 Port clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-004 Port por  input  1  is the reset: asynchronous and active-high.
REQ-005 Port uart_viol  input  1  is the UART-region memory-protection violation request, level, sampled each cycle.
REQ-006 Port irq_viol  input  1  is the interrupt-in-TCB violation request, level, sampled each cycle.
REQ-007 Port pc  input  16  is the current CPU program counter.
REQ-008 Port clr_cause  input  1  is a single-cycle request to clear the cause and PC log.
REQ-009 Port reset  output  1  is the stretched, registered CPU reset request.
REQ-010 Port cause  output  2  is the sticky cause log: bit0 UART violation, bit1 IRQ violation.
REQ-011 Port viol_pc  output  16  is the PC captured at the first violation of an episode.
REQ-012 Port viol_count  output  8  is the saturating count of violation cycles accepted since por.
REQ-013 Port busy  output  1  is high in ASSERT and COOLDOWN.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ASSERT, COOLDOWN.
REQ-015 "Violation" SHALL mean uart_viol | irq_viol sampled high at a rising edge.
REQ-016 IDLE + violation: next state ASSERT, reset=1 from the following cycle (latency 1), viol_pc<=pc, cause<={irq_viol,uart_viol}.
REQ-017 ASSERT: reset SHALL be high for exactly RST_CYCLES consecutive cycles, then the FSM enters COOLDOWN with reset=0.
REQ-018 Violation in ASSERT: OR the sampled bits into cause; the pulse is not extended; viol_pc is unchanged.
REQ-019 COOLDOWN: reset=0 for exactly COOLDOWN_CYCLES cycles, then IDLE.
REQ-020 Violation in COOLDOWN: latch a pending flag and OR the bits into cause.
REQ-021 COOLDOWN exit with pending set: go directly to ASSERT and clear pending; viol_pc is unchanged.
REQ-022 COOLDOWN exit without pending: go to IDLE.
REQ-023 viol_count SHALL increment by 1 per cycle in which a violation is sampled, in any state.
REQ-024 viol_count SHALL saturate at 255 and never wrap.
REQ-025 Simultaneous uart_viol and irq_viol SHALL set both cause bits and add 1 to viol_count.
REQ-026 clr_cause SHALL take effect only in IDLE; it clears cause and viol_pc to 0 and leaves viol_count unchanged.
REQ-027 clr_cause is ignored in ASSERT and COOLDOWN.
REQ-028 clr_cause and a violation in the same IDLE cycle: the violation wins and REQ-016 applies.
REQ-029 reset and busy SHALL be flip-flop outputs with no combinational path from inputs.

Reset
REQ-030 On por high, asynchronously: state=IDLE, reset=0, busy=0, cause=0, viol_pc=0, viol_count=0, pending=0, internal counters=0.
REQ-031 Violations sampled while por is high SHALL be discarded.
REQ-032 por asserted mid-ASSERT SHALL abort the pulse immediately with no residual pending.
REQ-033 After por deasserts, the first rising edge SHALL evaluate inputs normally.

Verification
REQ-034 Single pulse: uart_viol=1 for 1 cycle at pc=16'hA010 in IDLE -> reset high cycles 1..16, cause=2'b01, viol_pc=16'hA010, viol_count=1, IDLE after 2 cooldown cycles.
REQ-035 Re-trigger: irq_viol=1 during ASSERT cycle 5, then irq_viol=1 during COOLDOWN -> first pulse stays 16 cycles, cause=2'b11, exactly 2 low cycles, second 16-cycle pulse, viol_pc holds the first value, viol_count=3.
REQ-036 Simultaneous violation: both inputs high 1 cycle -> cause=2'b11, viol_count=1, one 16-cycle pulse.
REQ-037 Saturation: hold uart_viol high for 300 cycles -> viol_count=255 and stays at 255; reset keeps pulsing with 2-cycle gaps.
REQ-038 Clear rules: clr_cause during ASSERT -> no effect; clr_cause in IDLE -> cause=0 and viol_pc=0 with viol_count kept; clr_cause together with uart_viol in IDLE -> cause=2'b01.
REQ-039 por mid-ASSERT: por at ASSERT cycle 7 -> reset=0 immediately and all outputs 0; no pulse after por release without a new violation.

Source files
------------

// File: rtl/violation_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : violation_reset_ctrl
// Purpose  : Turns memory-protection violations into a stretched CPU reset
//            pulse with a cooldown gap, and logs cause, PC and count.
// Revision : 1.0 - initial release
// ============================================================================
module violation_reset_ctrl #(
    parameter int unsigned RST_CYCLES      = 16,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        por,
    input  logic        uart_viol,
    input  logic        irq_viol,
    input  logic [15:0] pc,
    input  logic        clr_cause,
    output logic        reset,
    output logic [1:0]  cause,
    output logic [15:0] viol_pc,
    output logic [7:0]  viol_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Counters are loaded with N-1 so that a terminal value of zero spans N cycles.
    localparam logic [7:0] c_rst_load  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] c_cool_load = 8'(COOLDOWN_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_pending;
    logic        r_reset;
    logic        r_busy;
    logic [1:0]  r_cause;
    logic [15:0] r_viol_pc;
    logic [7:0]  r_viol_count;

    logic        w_viol;
    logic [1:0]  w_bits;

    assign w_bits = {irq_viol, uart_viol};
    assign w_viol = uart_viol | irq_viol;

    always_ff @(posedge clk or posedge por) begin
        if (por) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_pending    <= 1'b0;
            r_reset      <= 1'b0;
            r_busy       <= 1'b0;
            r_cause      <= 2'b00;
            r_viol_pc    <= 16'h0000;
            r_viol_count <= 8'd0;
        end else begin
            if (w_viol && (r_viol_count != 8'hFF)) begin
                r_viol_count <= r_viol_count + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_viol) begin
                        r_state   <= ST_ASSERT;
                        r_cnt     <= c_rst_load;
                        r_reset   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cause   <= w_bits;
                        r_viol_pc <= pc;
                    end else if (clr_cause) begin
                        r_cause   <= 2'b00;
                        r_viol_pc <= 16'h0000;
                    end
                end

                ST_ASSERT: begin
                    r_cause <= r_cause | w_bits;
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_COOLDOWN;
                        r_cnt   <= c_cool_load;
                        r_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                ST_COOLDOWN: begin
                    r_cause <= r_cause | w_bits;
                    if (r_cnt == 8'd0) begin
                        // A violation on the final cooldown cycle still counts as pending.
                        if (r_pending || w_viol) begin
                            r_state   <= ST_ASSERT;
                            r_cnt     <= c_rst_load;
                            r_reset   <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                        r_pending <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        if (w_viol) begin
                            r_pending <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= 8'd0;
                    r_pending <= 1'b0;
                    r_reset   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign reset      = r_reset;
    assign busy       = r_busy;
    assign cause      = r_cause;
    assign viol_pc    = r_viol_pc;
    assign viol_count = r_viol_count;

endmodule
`default_nettype wire

// File: tb/tb_violation_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_violation_reset_ctrl
// Purpose  : Directed self-checking bench for violation_reset_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_violation_reset_ctrl;

    logic        clk;
    logic        por;
    logic        uart_viol;
    logic        irq_viol;
    logic [15:0] pc;
    logic        clr_cause;
    logic        reset;
    logic [1:0]  cause;
    logic [15:0] viol_pc;
    logic [7:0]  viol_count;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    violation_reset_ctrl #(
        .RST_CYCLES      (16),
        .COOLDOWN_CYCLES (2)
    ) dut (
        .clk        (clk),
        .por        (por),
        .uart_viol  (uart_viol),
        .irq_viol   (irq_viol),
        .pc         (pc),
        .clr_cause  (clr_cause),
        .reset      (reset),
        .cause      (cause),
        .viol_pc    (viol_pc),
        .viol_count (viol_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_por();
        por = 1'b1;
        step();
        step();
        por = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            k++;
            step();
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int lowrun;
        int badgap;
        int gaps;
        int seen_high;
        por       = 1'b1;
        uart_viol = 1'b0;
        irq_viol  = 1'b0;
        pc        = 16'h0000;
        clr_cause = 1'b0;
        step();
        // Violation while por is high must be discarded.
        uart_viol = 1'b1;
        step();
        chk("rst_reset", {31'd0, reset}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cause", {30'd0, cause}, 32'd0);
        chk("rst_pc", {16'd0, viol_pc}, 32'd0);
        chk("rst_count", {24'd0, viol_count}, 32'd0);
        uart_viol = 1'b0;
        por = 1'b0;
        step();

        // Single pulse
        pc = 16'hA010; uart_viol = 1'b1;
        step();
        uart_viol = 1'b0;
        chk("s_cause", {30'd0, cause}, 32'd1);
        chk("s_pc", {16'd0, viol_pc}, 32'hA010);
        chk("s_count", {24'd0, viol_count}, 32'd1);
        n = 0;
        while (reset === 1'b1 && n < 300) begin n++; step(); end
        chk("s_pulse_len", n, 16);
        m = 0;
        while (busy === 1'b1 && reset === 1'b0 && m < 20) begin m++; step(); end
        chk("s_cool_len", m, 2);
        chk("s_idle", {31'd0, busy}, 32'd0);

        // Re-trigger during ASSERT and COOLDOWN
        do_por();
        pc = 16'hB000; uart_viol = 1'b1;
        step();
        uart_viol = 1'b0; pc = 16'hC000;
        n = 0;
        while (reset === 1'b1 && n < 300) begin
            n++;
            irq_viol = (n == 5);
            step();
        end
        irq_viol = 1'b0;
        chk("rt_pulse1", n, 16);
        chk("rt_cause", {30'd0, cause}, 32'd3);
        m = 0;
        while (busy === 1'b1 && reset === 1'b0 && m < 20) begin
            m++;
            irq_viol = (m == 1);
            step();
        end
        irq_viol = 1'b0;
        chk("rt_gap", m, 2);
        n = 0;
        while (reset === 1'b1 && n < 300) begin n++; step(); end
        chk("rt_pulse2", n, 16);
        chk("rt_pc", {16'd0, viol_pc}, 32'hB000);
        chk("rt_count", {24'd0, viol_count}, 32'd3);
        wait_idle("rt_idle");

        // Simultaneous violation
        do_por();
        uart_viol = 1'b1; irq_viol = 1'b1; pc = 16'h0042;
        step();
        uart_viol = 1'b0; irq_viol = 1'b0;
        chk("sim_cause", {30'd0, cause}, 32'd3);
        chk("sim_count", {24'd0, viol_count}, 32'd1);
        n = 0;
        while (reset === 1'b1 && n < 300) begin n++; step(); end
        chk("sim_pulse", n, 16);
        wait_idle("sim_idle");
        chk("sim_count_end", {24'd0, viol_count}, 32'd1);

        // Saturation with uart held high
        do_por();
        uart_viol = 1'b1;
        lowrun = 0; badgap = 0; gaps = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 100 || i == 255 || i == 256 || i == 300)
                chk("sat_count", {24'd0, viol_count}, (i < 255) ? i : 255);
            if (reset === 1'b0) begin
                lowrun++;
            end else if (lowrun != 0) begin
                if (lowrun != 2) badgap++;
                lowrun = 0;
                gaps++;
            end
        end
        chk("sat_badgap", badgap, 0);
        chk("sat_gaps", gaps, 16);
        uart_viol = 1'b0;
        wait_idle("sat_idle");
        chk("sat_hold", {24'd0, viol_count}, 32'd255);

        // Clear rules
        do_por();
        pc = 16'h1234; uart_viol = 1'b1;
        step();
        uart_viol = 1'b0;
        step();
        clr_cause = 1'b1;
        step();
        clr_cause = 1'b0;
        chk("clr_assert_cause", {30'd0, cause}, 32'd1);
        chk("clr_assert_pc", {16'd0, viol_pc}, 32'h1234);
        wait_idle("clr_idle");
        clr_cause = 1'b1;
        step();
        clr_cause = 1'b0;
        chk("clr_cause", {30'd0, cause}, 32'd0);
        chk("clr_pc", {16'd0, viol_pc}, 32'd0);
        chk("clr_count", {24'd0, viol_count}, 32'd1);
        pc = 16'h5555; clr_cause = 1'b1; uart_viol = 1'b1;
        step();
        clr_cause = 1'b0; uart_viol = 1'b0;
        chk("clrv_cause", {30'd0, cause}, 32'd1);
        chk("clrv_pc", {16'd0, viol_pc}, 32'h5555);
        chk("clrv_reset", {31'd0, reset}, 32'd1);
        chk("clrv_count", {24'd0, viol_count}, 32'd2);
        wait_idle("clrv_idle");

        // por mid-ASSERT
        do_por();
        pc = 16'h7777; uart_viol = 1'b1;
        step();
        uart_viol = 1'b0;
        for (int i = 1; i < 7; i++) step();
        chk("por_pre_reset", {31'd0, reset}, 32'd1);
        #2;
        por = 1'b1;
        #1;
        chk("por_reset", {31'd0, reset}, 32'd0);
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_cause", {30'd0, cause}, 32'd0);
        chk("por_pc", {16'd0, viol_pc}, 32'd0);
        chk("por_count", {24'd0, viol_count}, 32'd0);
        uart_viol = 1'b1;
        step();
        step();
        uart_viol = 1'b0;
        chk("por_discard", {24'd0, viol_count}, 32'd0);
        por = 1'b0;
        seen_high = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (reset !== 1'b0 || busy !== 1'b0) seen_high++;
        end
        chk("por_no_residual", seen_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
